// File: rtl/frame_reader_pkg.sv
// Shared types and default geometry for the frame-buffer read master.
package frame_reader_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FRM, STREAM, DRAIN} state_t;

  localparam int H_PIX     = 320;
  localparam int V_PIX     = 240;
  localparam int FRAME_PIX = H_PIX * V_PIX;
  localparam int ADR_W     = 19;
  localparam int DAT_W     = 12;
  localparam int TAG_N     = 3;

  // Beat layout in the output FIFO: {sof, eol, eof, data}.
  function automatic int beat_w(input int dat_w);
    return dat_w + TAG_N;
  endfunction
endpackage

// File: rtl/frame_reader_if.sv
// Frame-buffer read port plus outgoing pixel stream.
interface frame_reader_if #(
  parameter int ADR_W = frame_reader_pkg::ADR_W,
  parameter int DAT_W = frame_reader_pkg::DAT_W
);
  logic             mem_re_o;
  logic [ADR_W-1:0] mem_adr_o;
  logic [DAT_W-1:0] mem_dat_i;
  logic             pix_valid_o;
  logic             pix_ready_i;
  logic [DAT_W-1:0] pix_data_o;
  logic             pix_sof_o;
  logic             pix_eol_o;
  logic             pix_eof_o;

  modport master (
    output mem_re_o, mem_adr_o, pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o,
    input  mem_dat_i, pix_ready_i
  );
  modport slave (
    input  mem_re_o, mem_adr_o, pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o,
    output mem_dat_i, pix_ready_i
  );
endinterface

// File: rtl/frame_reader_pix_skid_fifo.sv
// Two-entry FIFO holding returned pixels with their frame markers.
module pix_skid_fifo #(
  parameter int W = 15
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);
  logic [1:0][W-1:0] r_mem;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (flush_i) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (push_i) begin
        r_mem[r_wp] <= din_i;
        r_wp        <= ~r_wp;
      end
      if (pop_i) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o = r_cnt;
  assign head_o  = r_mem[r_rp];
endmodule

// File: rtl/frame_reader.sv
// Raster-order reader of a completed frame; credit-limited reads feed a
// 2-deep FIFO so the stream runs at one pixel per cycle under full ready.
module frame_reader #(
  parameter int H_PIX = frame_reader_pkg::H_PIX,
  parameter int V_PIX = frame_reader_pkg::V_PIX,
  parameter int ADR_W = frame_reader_pkg::ADR_W,
  parameter int DAT_W = frame_reader_pkg::DAT_W
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            frame_rdy_i,
  frame_reader_if.master  bus,
  output logic            busy_o,
  output logic            done_o
);
  import frame_reader_pkg::*;

  localparam int BW       = beat_w(DAT_W);
  localparam int CW       = $clog2(H_PIX + 1);
  localparam int LAST_ADR = H_PIX * V_PIX - 1;

  state_t           r_state, w_nxt;
  logic [ADR_W-1:0] r_rd_adr;
  logic [CW-1:0]    r_col;
  logic             r_inflight;
  logic [2:0]       r_tag;
  logic             r_done;
  logic [1:0]       w_cnt;
  logic [BW-1:0]    w_head;
  logic [2:0]       w_credit;
  logic [2:0]       w_tag;
  logic             w_valid, w_pop, w_issue, w_last_issue, w_eof_pop, w_flush;

  assign w_valid      = (w_cnt != 2'd0);
  assign w_pop        = w_valid & bus.pix_ready_i;
  // Occupancy after this cycle's pop; at most two beats may be owed to the FIFO.
  assign w_credit     = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == STREAM) & ~abort_i & (w_credit < 3'd2);
  assign w_last_issue = w_issue & (r_rd_adr == ADR_W'(LAST_ADR));
  assign w_tag        = {r_rd_adr == '0, r_col == CW'(H_PIX - 1), r_rd_adr == ADR_W'(LAST_ADR)};
  assign w_eof_pop    = w_pop & w_head[DAT_W];
  assign w_flush      = abort_i & (r_state != IDLE);

  always_comb begin
    w_nxt = r_state;
    if (abort_i && r_state != IDLE) w_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:     if (start_i)      w_nxt = WAIT_FRM;
        WAIT_FRM: if (frame_rdy_i)  w_nxt = STREAM;
        STREAM:   if (w_last_issue) w_nxt = DRAIN;
        DRAIN:    if (w_eof_pop)    w_nxt = IDLE;
        default:                    w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rd_adr   <= '0;
      r_col      <= '0;
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_inflight <= w_issue;
      r_tag      <= w_tag;
      r_done     <= w_eof_pop & ~abort_i & (r_state == DRAIN);
      if (r_state == WAIT_FRM && frame_rdy_i) begin
        r_rd_adr <= '0;
        r_col    <= '0;
      end else if (w_issue) begin
        r_rd_adr <= r_rd_adr + ADR_W'(1);
        r_col    <= (r_col == CW'(H_PIX - 1)) ? '0 : r_col + CW'(1);
      end
    end
  end

  pix_skid_fifo #(.W(BW)) u_fifo (
    .clk_i   (clk_i),
    .rst     (rst),
    .push_i  (r_inflight),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .din_i   ({r_tag, bus.mem_dat_i}),
    .count_o (w_cnt),
    .head_o  (w_head)
  );

  assign bus.mem_re_o    = w_issue;
  assign bus.mem_adr_o   = w_issue ? r_rd_adr : '0;
  assign bus.pix_valid_o = w_valid;
  assign bus.pix_data_o  = w_valid ? w_head[DAT_W-1:0] : '0;
  assign bus.pix_sof_o   = w_valid & w_head[BW-1];
  assign bus.pix_eol_o   = w_valid & w_head[BW-2];
  assign bus.pix_eof_o   = w_valid & w_head[DAT_W];
  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
endmodule
